// File: rtl/pwm_stream_loader_pkg.sv
// rtl/pwm_stream_loader_pkg.sv - shared FSM encoding, parameter defaults and legal beat widths
package pwm_stream_loader_pkg;

    localparam int PWM_DEF_DRAM = 32;
    localparam int PWM_DEF_WPB  = 2;
    localparam int PWM_DEF_ADDR = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALF = 2'd2,
        ST_DONE = 2'd3
    } pwm_state_e;

    // Only two or four words per beat map onto the two BRAM ports.
    function automatic bit pwm_wpb_legal(input int wpb);
        return (wpb == 2) || (wpb == 4);
    endfunction

endpackage

// File: rtl/pwm_stream_addr_gen.sv
// rtl/pwm_stream_addr_gen.sv - port A/B word addresses for one beat (or beat half)
module pwm_stream_addr_gen
    import pwm_stream_loader_pkg::*;
#(
    parameter int PRM_WPB  = PWM_DEF_WPB,
    parameter int PRM_ADDR = PWM_DEF_ADDR
) (
    input  logic [PRM_ADDR-1:0] base_i,
    input  logic [PRM_ADDR-1:0] beat_i,
    input  logic                half_i,
    output logic [PRM_ADDR-1:0] addr_a_o,
    output logic [PRM_ADDR-1:0] addr_b_o
);

    localparam int WPB_SHIFT = (PRM_WPB == 4) ? 2 : 1;

    logic [PRM_ADDR-1:0] beat_off;
    logic [PRM_ADDR-1:0] half_off;

    // Arithmetic is modulo 2^PRM_ADDR, so a transfer may wrap past the top word.
    assign beat_off = beat_i << WPB_SHIFT;
    assign half_off = {{(PRM_ADDR-2){1'b0}}, half_i, 1'b0};
    assign addr_a_o = base_i + beat_off + half_off;
    assign addr_b_o = addr_a_o + PRM_ADDR'(1);

endmodule

// File: rtl/pwm_stream_loader.sv
// rtl/pwm_stream_loader.sv - stream-to-dual-port BRAM loader; PWM_STREAM_TLAST_EN adds TLAST checking
module pwm_stream_loader
    import pwm_stream_loader_pkg::*;
#(
    parameter int PRM_DRAM = PWM_DEF_DRAM,
    parameter int PRM_WPB  = PWM_DEF_WPB,
    parameter int PRM_DAXI = PRM_WPB * PRM_DRAM,
    parameter int PRM_ADDR = PWM_DEF_ADDR
) (
    input  logic                iSYS_CLK,
    input  logic                iSYS_RST,
    input  logic                iFSM_START,
    input  logic [PRM_ADDR-1:0] iCFG_BASE,
    input  logic [PRM_ADDR-1:0] iCFG_BEATS,
    output logic                oFSM_DONE,
    input  logic                iRs_Tvalid,
    input  logic [PRM_DAXI-1:0] iRs_Tdata,
    input  logic                iRs_Tlast,
    output logic                oRs_Tready,
    output logic                oB1_enA,
    output logic                oB1_weA,
    output logic [PRM_ADDR-1:0] oB1_addrA,
    output logic [PRM_DRAM-1:0] oB1_dinA,
    output logic                oB1_enB,
    output logic                oB1_weB,
    output logic [PRM_ADDR-1:0] oB1_addrB,
    output logic [PRM_DRAM-1:0] oB1_dinB,
    output logic                oERR
);

    generate
        if (!pwm_wpb_legal(PRM_WPB)) begin : g_bad_wpb
            $error("pwm_stream_loader: PRM_WPB must be 2 or 4");
        end
    endgenerate

    pwm_state_e          state_q, state_d;
    logic [PRM_ADDR-1:0] base_q, beats_q, cnt_q, cnt_d;
    logic                start_ok, all_accepted, tready, accept, is_half, wr_fire;
    logic [PRM_ADDR-1:0] gen_beat, gen_addr_a, gen_addr_b;
    logic [PRM_DRAM-1:0] hold_a, hold_b, word_a, word_b;
    logic                wr_en_q;
    logic [PRM_ADDR-1:0] addr_a_q, addr_b_q;
    logic [PRM_DRAM-1:0] din_a_q, din_b_q;

    assign start_ok     = (state_q == ST_IDLE) && iFSM_START;
    assign all_accepted = (cnt_q == beats_q);
    assign tready       = (state_q == ST_RUN) && !all_accepted && !iSYS_RST;
    assign accept       = tready && iRs_Tvalid;
    assign is_half      = (state_q == ST_HALF);
    assign wr_fire      = accept || is_half;

    // The HALF cycle writes the upper words of the beat counted on the previous cycle.
    assign gen_beat = is_half ? (cnt_q - PRM_ADDR'(1)) : cnt_q;

    pwm_stream_addr_gen #(
        .PRM_WPB  (PRM_WPB),
        .PRM_ADDR (PRM_ADDR)
    ) u_addr_gen (
        .base_i   (base_q),
        .beat_i   (gen_beat),
        .half_i   (is_half),
        .addr_a_o (gen_addr_a),
        .addr_b_o (gen_addr_b)
    );

    generate
        if (PRM_WPB == 4) begin : g_hold
            logic [PRM_DRAM-1:0] hold_a_q, hold_b_q;
            always_ff @(posedge iSYS_CLK) begin
                if (iSYS_RST) begin
                    hold_a_q <= '0;
                    hold_b_q <= '0;
                end else if (accept) begin
                    hold_a_q <= iRs_Tdata[2*PRM_DRAM +: PRM_DRAM];
                    hold_b_q <= iRs_Tdata[3*PRM_DRAM +: PRM_DRAM];
                end
            end
            assign hold_a = hold_a_q;
            assign hold_b = hold_b_q;
        end else begin : g_no_hold
            assign hold_a = '0;
            assign hold_b = '0;
        end
    endgenerate

    assign word_a = is_half ? hold_a : iRs_Tdata[0 +: PRM_DRAM];
    assign word_b = is_half ? hold_b : iRs_Tdata[PRM_DRAM +: PRM_DRAM];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (iFSM_START) begin
                    cnt_d   = '0;
                    state_d = (iCFG_BEATS == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Once every beat is in, this RUN cycle carries the final write; DONE follows it.
                if (accept) begin
                    cnt_d = cnt_q + PRM_ADDR'(1);
                    if (PRM_WPB == 4) begin
                        state_d = ST_HALF;
                    end
                end else if (all_accepted) begin
                    state_d = ST_DONE;
                end
            end
            ST_HALF: state_d = ST_RUN;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iSYS_CLK) begin
        if (iSYS_RST) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            beats_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start_ok) begin
                base_q  <= iCFG_BASE;
                beats_q <= iCFG_BEATS;
            end
        end
    end

    always_ff @(posedge iSYS_CLK) begin
        if (iSYS_RST) begin
            wr_en_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            din_a_q  <= '0;
            din_b_q  <= '0;
        end else begin
            wr_en_q <= wr_fire;
            if (wr_fire) begin
                addr_a_q <= gen_addr_a;
                addr_b_q <= gen_addr_b;
                din_a_q  <= word_a;
                din_b_q  <= word_b;
            end
        end
    end

    assign oFSM_DONE  = (state_q == ST_DONE) && !iSYS_RST;
    assign oRs_Tready = tready;
    assign oB1_enA    = wr_en_q;
    assign oB1_weA    = wr_en_q;
    assign oB1_addrA  = addr_a_q;
    assign oB1_dinA   = din_a_q;
    assign oB1_enB    = wr_en_q;
    assign oB1_weB    = wr_en_q;
    assign oB1_addrB  = addr_b_q;
    assign oB1_dinB   = din_b_q;

`ifdef PWM_STREAM_TLAST_EN
    logic last_beat;
    logic err_q;

    assign last_beat = (cnt_q == beats_q - PRM_ADDR'(1));

    always_ff @(posedge iSYS_CLK) begin
        if (iSYS_RST) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (accept && (iRs_Tlast != last_beat)) begin
            err_q <= 1'b1;
        end
    end

    assign oERR = err_q;
`else
    logic unused_tlast;
    assign unused_tlast = iRs_Tlast;
    assign oERR         = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_stream_loader.sv
// tb/tb_pwm_stream_loader.sv - scoreboard bench for pwm_stream_loader at two and four words per beat
module tb_pwm_stream_loader;

    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] addr_a;
        logic [DW-1:0] din_a;
        logic [AW-1:0] addr_b;
        logic [DW-1:0] din_b;
        bit            last;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start [2];
    logic [AW-1:0] cbase [2];
    logic [AW-1:0] cbeats [2];
    logic          valid [2];
    logic          tlast [2];
    logic [2*DW-1:0] tdata2;
    logic [4*DW-1:0] tdata4;
    logic          done [2], ready [2], err [2];
    logic          en_a [2], we_a [2], en_b [2], we_b [2];
    logic [AW-1:0] addr_a [2], addr_b [2];
    logic [DW-1:0] din_a [2], din_b [2];

    wr_t exp_q0 [$];
    wr_t exp_q1 [$];
    bit  due [2];
    bit  zero [2];
    int  done_cnt [2];
    int  exp_done [2];
    int  total = 0;
    int  bad = 0;
    int  tag = 0;

    always #5 clk = ~clk;

    pwm_stream_loader #(.PRM_WPB(2)) dut2 (
        .iSYS_CLK(clk), .iSYS_RST(rst), .iFSM_START(start[0]),
        .iCFG_BASE(cbase[0]), .iCFG_BEATS(cbeats[0]), .oFSM_DONE(done[0]),
        .iRs_Tvalid(valid[0]), .iRs_Tdata(tdata2), .iRs_Tlast(tlast[0]), .oRs_Tready(ready[0]),
        .oB1_enA(en_a[0]), .oB1_weA(we_a[0]), .oB1_addrA(addr_a[0]), .oB1_dinA(din_a[0]),
        .oB1_enB(en_b[0]), .oB1_weB(we_b[0]), .oB1_addrB(addr_b[0]), .oB1_dinB(din_b[0]),
        .oERR(err[0])
    );

    pwm_stream_loader #(.PRM_WPB(4)) dut4 (
        .iSYS_CLK(clk), .iSYS_RST(rst), .iFSM_START(start[1]),
        .iCFG_BASE(cbase[1]), .iCFG_BEATS(cbeats[1]), .oFSM_DONE(done[1]),
        .iRs_Tvalid(valid[1]), .iRs_Tdata(tdata4), .iRs_Tlast(tlast[1]), .oRs_Tready(ready[1]),
        .oB1_enA(en_a[1]), .oB1_weA(we_a[1]), .oB1_addrA(addr_a[1]), .oB1_dinA(din_a[1]),
        .oB1_enB(en_b[1]), .oB1_weB(we_b[1]), .oB1_addrB(addr_b[1]), .oB1_dinB(din_b[1]),
        .oERR(err[1])
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", name, got, req);
        end
    endtask

    function automatic logic [DW-1:0] word(input int n, input int k);
        if (tag == 0) return DW'(n);
        return {8'(tag), 8'(k), 16'(n)};
    endfunction

    task automatic mon(input int s);
        wr_t e;
        bit  popped_last;
        popped_last = 1'b0;
        if (en_a[s] || en_b[s] || we_a[s] || we_b[s]) begin
            chk("en_we_together", 64'({en_a[s], we_a[s], en_b[s], we_b[s]}), 64'(4'hF));
            total++;
            if ((s == 0 && exp_q0.size() == 0) || (s == 1 && exp_q1.size() == 0)) begin
                bad++;
                $display("FAIL unexpected_write dut%0d: addrA=%0d addrB=%0d required no write", s, addr_a[s], addr_b[s]);
            end else begin
                if (s == 0) e = exp_q0.pop_front();
                else        e = exp_q1.pop_front();
                if (addr_a[s] !== e.addr_a || din_a[s] !== e.din_a ||
                    addr_b[s] !== e.addr_b || din_b[s] !== e.din_b) begin
                    bad++;
                    $display("FAIL write dut%0d: got A=%0d/%0h B=%0d/%0h required A=%0d/%0h B=%0d/%0h",
                             s, addr_a[s], din_a[s], addr_b[s], din_b[s], e.addr_a, e.din_a, e.addr_b, e.din_b);
                end
                popped_last = e.last;
            end
        end
        if (done[s] === 1'b1 || due[s]) begin
            total++;
            if (done[s] !== 1'b1) begin
                bad++;
                $display("FAIL done_after_last_write dut%0d: got done=%0b required 1", s, done[s]);
            end else if (!due[s] && !zero[s]) begin
                bad++;
                $display("FAIL done_unexpected dut%0d: got done=1 required 0", s);
            end
        end
        if (done[s] === 1'b1) begin
            done_cnt[s]++;
            zero[s] = 1'b0;
        end
        due[s] = popped_last;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            mon(0);
            mon(1);
        end
    end

    task automatic do_start(input int s, input int base, input int beats);
        start[s]  = 1'b1;
        cbase[s]  = AW'(base);
        cbeats[s] = AW'(beats);
        @(posedge clk); #1;
        start[s]  = 1'b0;
    endtask

    task automatic run_xfer(input int s, input int base, input int beats, input int nsend,
                            input int gap, input int bad_tl, input int poke,
                            output int hist, output int stalls);
        wr_t e;
        bit  exp_err;
        bit  abort;
        hist    = 0;
        stalls  = 0;
        exp_err = 1'b0;
        abort   = 1'b0;
        for (int i = 0; i < nsend; i++) begin
            if (s == 0) begin
                e.addr_a = AW'(base + 2*i);     e.din_a = word(i, 0);
                e.addr_b = AW'(base + 2*i + 1); e.din_b = word(i, 1);
                e.last   = (i == beats - 1);
                exp_q0.push_back(e);
            end else begin
                for (int j = 0; j < 2; j++) begin
                    e.addr_a = AW'(base + 4*i + 2*j);     e.din_a = word(i, 2*j);
                    e.addr_b = AW'(base + 4*i + 2*j + 1); e.din_b = word(i, 2*j + 1);
                    e.last   = (i == beats - 1) && (j == 1);
                    exp_q1.push_back(e);
                end
            end
        end
        for (int i = 0; i < nsend && !abort; i++) begin
            int  guard;
            bit  got;
            if (gap != 0) begin
                while ($urandom_range(1, 0) == 0) begin
                    valid[s] = 1'b0;
                    @(posedge clk); #1;
                end
            end
            valid[s] = 1'b1;
            tlast[s] = (i == beats - 1) ^ (i == bad_tl);
            if (s == 0) tdata2 = {word(i, 1), word(i, 0)};
            else        tdata4 = {word(i, 3), word(i, 2), word(i, 1), word(i, 0)};
            if (i == poke) begin
                start[s]  = 1'b1;
                cbase[s]  = AW'(base + 7);
                cbeats[s] = AW'(1);
            end
            guard = 0;
            got   = 1'b0;
            while (!got && guard < 20) begin
                @(negedge clk);
                hist = (hist << 1) | int'(ready[s]);
                if (ready[s] === 1'b1) got = 1'b1;
                else                   stalls++;
                @(posedge clk); #1;
                guard++;
            end
            start[s] = 1'b0;
            if (!got) begin
                chk("accept_timeout", 64'(0), 64'(1));
                abort = 1'b1;
            end else begin
                exp_err = exp_err | (tlast[s] != (i == beats - 1));
`ifdef PWM_STREAM_TLAST_EN
                chk("err_after_beat", 64'(err[s]), 64'(exp_err));
`else
                chk("err_tied_low", 64'(err[s]), 64'(0));
`endif
            end
        end
        valid[s] = 1'b0;
        tlast[s] = 1'b0;
    endtask

    task automatic wait_done(input int s, input string name);
        int guard;
        guard = 0;
        while (done_cnt[s] < exp_done[s] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk(name, 64'(done_cnt[s]), 64'(exp_done[s]));
    endtask

    task automatic chk_zero(input int s, input string name);
        chk(name, 64'({done[s], ready[s], err[s], en_a[s], we_a[s], en_b[s], we_b[s]}), 64'(0));
        chk(name, 64'({addr_a[s], addr_b[s]}), 64'(0));
        chk(name, 64'({din_a[s], din_b[s]}), 64'(0));
    endtask

    initial begin
        int hist, stalls;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            start[s] = 1'b0; cbase[s] = '0; cbeats[s] = '0;
            valid[s] = 1'b0; tlast[s] = 1'b0;
            due[s] = 1'b0; zero[s] = 1'b0; done_cnt[s] = 0; exp_done[s] = 0;
        end
        tdata2 = '0;
        tdata4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0, "reset_state_wpb2");
        chk_zero(1, "reset_state_wpb4");
        rst = 1'b0;
        @(posedge clk); #1;

        // Full 2048-beat load at two words per beat, valid held high
        tag = 0;
        do_start(0, 0, 2048);
        run_xfer(0, 0, 2048, 2048, 0, -1, -1, hist, stalls);
        chk("wpb2_ready_held", 64'(stalls), 64'(0));
        exp_done[0]++;
        wait_done(0, "wpb2_full_done");

        // Four words per beat, with a stray start mid-transfer that must be ignored
        tag = 1;
        do_start(1, 16, 3);
        run_xfer(1, 16, 3, 3, 0, -1, 1, hist, stalls);
        chk("wpb4_ready_pattern", 64'(hist), 64'(5'b10101));
        exp_done[1]++;
        wait_done(1, "wpb4_one_done");

        // Randomly gapped valid
        tag = 2;
        do_start(0, 300, 8);
        run_xfer(0, 300, 8, 8, 1, -1, -1, hist, stalls);
        exp_done[0]++;
        wait_done(0, "wpb2_gapped_done");
        do_start(1, 40, 6);
        run_xfer(1, 40, 6, 6, 1, -1, -1, hist, stalls);
        exp_done[1]++;
        wait_done(1, "wpb4_gapped_done");

        // Address wrap past the top word
        tag = 3;
        do_start(0, 4094, 2);
        run_xfer(0, 4094, 2, 2, 0, -1, -1, hist, stalls);
        exp_done[0]++;
        wait_done(0, "wrap_done");

        // Zero-beat start goes straight to DONE
        zero[0] = 1'b1;
        do_start(0, 5, 0);
        chk("zero_beats_no_ready", 64'(ready[0]), 64'(0));
        chk("zero_beats_no_write", 64'({en_a[0], en_b[0]}), 64'(0));
        exp_done[0]++;
        wait_done(0, "zero_beats_done");

        // TLAST asserted early on the second beat
        tag = 4;
        do_start(1, 64, 4);
        run_xfer(1, 64, 4, 4, 0, 1, -1, hist, stalls);
        exp_done[1]++;
        wait_done(1, "tlast_bad_done");
`ifdef PWM_STREAM_TLAST_EN
        chk("err_sticky", 64'(err[1]), 64'(1));
`else
        chk("err_sticky_off", 64'(err[1]), 64'(0));
`endif
        do_start(1, 200, 1);
        chk("err_cleared_on_start", 64'(err[1]), 64'(0));
        run_xfer(1, 200, 1, 1, 0, -1, -1, hist, stalls);
        exp_done[1]++;
        wait_done(1, "tlast_clean_done");

        // Reset after 5 of 10 beats, then a fresh one-beat transfer
        tag = 5;
        do_start(0, 500, 10);
        run_xfer(0, 500, 10, 5, 0, -1, -1, hist, stalls);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk_zero(0, "mid_reset_wpb2");
        chk_zero(1, "mid_reset_wpb4");
        rst = 1'b0;
        @(posedge clk); #1;
        do_start(0, 100, 1);
        run_xfer(0, 100, 1, 1, 0, -1, -1, hist, stalls);
        exp_done[0]++;
        wait_done(0, "restart_done");

        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("scoreboard_empty_wpb2", 64'(exp_q0.size()), 64'(0));
        chk("scoreboard_empty_wpb4", 64'(exp_q1.size()), 64'(0));
        chk("done_count_wpb2", 64'(done_cnt[0]), 64'(exp_done[0]));
        chk("done_count_wpb4", 64'(done_cnt[1]), 64'(exp_done[1]));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: run still active at time limit, required completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/pwm_stream_loader.md
PWM_STREAM_LOADER -- requirements
Module: pwm_stream_loader

Interface
REQ-001 Parameter PRM_DRAM, default 32, SHALL set the BRAM word width.
REQ-002 Parameter PRM_WPB, default 2, SHALL set the words per stream beat; legal values are 2 and 4.
REQ-003 Parameter PRM_DAXI, default PRM_WPB*PRM_DRAM, SHALL set the stream data width.
REQ-004 Parameter PRM_ADDR, default 12, SHALL set the BRAM address width.
REQ-005 iSYS_CLK  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-006 iSYS_RST  in  1  SHALL be the synchronous, active-high reset.
REQ-007 iFSM_START  in  1  SHALL be a one-cycle start request.
REQ-008 iCFG_BASE  in  PRM_ADDR  SHALL be the first BRAM word address, latched at start.
REQ-009 iCFG_BEATS  in  PRM_ADDR  SHALL be the number of beats to load, latched at start.
REQ-010 oFSM_DONE  out  1  SHALL be a one-cycle completion pulse.
REQ-011 iRs_Tvalid  in  1  SHALL be the stream valid.
REQ-012 iRs_Tdata  in  PRM_DAXI  SHALL be the stream data; word k occupies bits [k*PRM_DRAM +: PRM_DRAM].
REQ-013 iRs_Tlast  in  1  SHALL be the stream last-beat marker.
REQ-014 oRs_Tready  out  1  SHALL be the stream ready.
REQ-015 oB1_enA/oB1_weA  out  1 each  SHALL be the port A enable and write enable.
REQ-016 oB1_addrA/oB1_dinA  out  PRM_ADDR/PRM_DRAM  SHALL be the port A address and write data.
REQ-017 oB1_enB/oB1_weB  out  1 each  SHALL be the port B enable and write enable.
REQ-018 oB1_addrB/oB1_dinB  out  PRM_ADDR/PRM_DRAM  SHALL be the port B address and write data.
REQ-019 oERR  out  1  SHALL be a sticky TLAST-mismatch flag.

Function
REQ-020 The FSM SHALL have the states IDLE, RUN, HALF and DONE.
- IDLE to RUN on iFSM_START.
- DONE always returns to IDLE on the next cycle.
REQ-021 iFSM_START SHALL be ignored outside IDLE.
REQ-022 A start with iCFG_BEATS=0 SHALL go IDLE to DONE, with no writes and no oRs_Tready.
REQ-023 oRs_Tready SHALL be 1 only in RUN.
REQ-024 A beat SHALL be accepted on a cycle with iRs_Tvalid and oRs_Tready both 1.
REQ-025 Word k of beat n SHALL be written to address iCFG_BASE + n*PRM_WPB + k, modulo 2^PRM_ADDR (wrap permitted).
REQ-026 Even words SHALL go to port A and odd words to port B.
REQ-027 Writes SHALL be registered: en and we are asserted the cycle after acceptance; en=we, asserted together.
REQ-028 PRM_WPB=2: both words of a beat SHALL be written in one cycle, and back-to-back beats SHALL be sustained at 1 beat/cycle.
REQ-029 PRM_WPB=4: after acceptance the FSM SHALL go RUN to HALF.
- Cycle 1 writes words 0/1; the HALF cycle writes words 2/3.
- The FSM then returns to RUN, giving 1 beat per 2 cycles.
REQ-030 After the write of the last beat's final words, the FSM SHALL enter DONE and oFSM_DONE SHALL be 1 for exactly that cycle.
REQ-031 Beats presented after the count is reached SHALL not be accepted.
REQ-032 Outside write cycles, enA/enB/weA/weB SHALL be 0; addr/din hold their last values.

Reset
REQ-033 While iSYS_RST=1, the FSM SHALL be IDLE and all of the following SHALL be 0: oFSM_DONE, oRs_Tready, oERR, all en/we, addr/din, and the beat counter.
REQ-034 Reset mid-transfer SHALL abort immediately, with no further writes and no DONE pulse.
REQ-035 A new start after reset SHALL behave as a fresh transfer.

Configuration
REQ-036 With PWM_STREAM_TLAST_EN defined, oERR SHALL set when iRs_Tlast=1 on a non-final accepted beat or iRs_Tlast=0 on the final beat.
- oERR clears only on reset or on the next accepted start.
- The transfer still completes normally.
REQ-037 Without PWM_STREAM_TLAST_EN, iRs_Tlast SHALL be ignored and oERR SHALL be tied to 0.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding, the default PRM_* values and the legal PRM_WPB set.
REQ-039 One sub-module, pwm_stream_addr_gen, SHALL produce the per-cycle A/B addresses from base, beat count and half index.

Verification
REQ-040 PRM_WPB=2, base 0, beats 2048, data {n,n}, valid continuous: ready is held high, and the final write is addrA=4094, dinA=2047, addrB=4095, dinB=2047; DONE occurs 1 cycle after the last write.
REQ-041 PRM_WPB=4, base 16, beats 3: ready toggles 1,0; the writes go to addresses 16..27 in order; exactly one DONE pulse is produced.
REQ-042 Valid is randomly gapped, 50% duty: the address sequence is unchanged and no write occurs without a handshake.
REQ-043 base 4094, beats 2, WPB=2: the writes go to addresses 4094/4095 then 0/1 (wrap).
REQ-044 Reset asserted after 5 beats of 10: all outputs are 0 the next cycle, and a restart with beats 1 writes one beat and pulses DONE.
REQ-045 With PWM_STREAM_TLAST_EN, beats 4 and Tlast on beat 2: oERR rises after beat 2 and stays high; DONE still occurs.
